// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Sequences machine-mode trap entry (exceptions and interrupts) and MRET
//   for the CSR file. Accepted traps write mepc, mcause, mtval and mstatus
//   one per cycle through the single CSR write port, then issue a one-cycle
//   PC redirect/flush. MRET writes mstatus, then redirects to mepc.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   exc_valid/ready     commit-stage exception request / accepted (idle)
//   exc_cause/pc/tval   exception code, faulting PC, trap value
//   mret_valid          MRET committed
//   irq_ok, irq_pc      instruction boundary flag, resume PC for interrupts
//   mstatus_q..mepc_q   current CSR values
//   csr_we/waddr/wdata  CSR write port (full-word, CSR file masks)
//   csr_busy            stall pipeline CSR access while sequencing
//   redirect_valid/pc   one-cycle PC redirect + flush, target

module csr_trap_ctrl #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned TVEC_VECTORED_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_valid,
    output logic            exc_ready,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            irq_ok,
    input  logic [XLEN-1:0] irq_pc,
    input  logic [XLEN-1:0] mstatus_q,
    input  logic [XLEN-1:0] mie_q,
    input  logic [XLEN-1:0] mip_q,
    input  logic [XLEN-1:0] mtvec_q,
    input  logic [XLEN-1:0] mepc_q,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_busy,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMcause,
        StWMtval,
        StWMstat,
        StMMstat,
        StRedir
    } state_t;

    state_t          r_state;
    state_t          w_state_d;

    // Values frozen at accept time
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_tval;
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;

    // Registered write port / redirect outputs
    logic            r_csr_we;
    logic [11:0]     r_csr_waddr;
    logic [XLEN-1:0] r_csr_wdata;
    logic            r_redir;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_we_d;
    logic [11:0]     w_waddr_d;
    logic [XLEN-1:0] w_wdata_d;
    logic            w_redir_d;
    logic [XLEN-1:0] w_redir_pc_d;

    logic            w_idle;
    logic [XLEN-1:0] w_irq_pend;
    logic            w_irq_take;
    logic [4:0]      w_irq_code;
    logic            w_take_exc;
    logic            w_take_irq;
    logic            w_take_mret;
    logic            w_take_trap;
    logic [XLEN-1:0] w_trap_epc;
    logic [XLEN-1:0] w_trap_cause;
    logic [XLEN-1:0] w_trap_tval;
    logic [XLEN-1:0] w_trap_mstatus;
    logic [XLEN-1:0] w_mret_mstatus;
    logic [XLEN-1:0] w_tvec_base;
    logic            w_vectored;
    logic [XLEN-1:0] w_trap_target;
    logic            w_unused_irq;

    assign w_idle     = (r_state == StIdle);
    assign w_irq_pend = mie_q & mip_q;
    assign w_irq_take = irq_ok & mstatus_q[3] & (w_irq_pend[11] | w_irq_pend[3] | w_irq_pend[7]);

    // MEI > MSI > MTI
    assign w_irq_code = w_irq_pend[11] ? 5'd11 : (w_irq_pend[3] ? 5'd3 : 5'd7);

    assign w_unused_irq = ^{w_irq_pend[XLEN-1:12], w_irq_pend[10:8], w_irq_pend[6:4],
                            w_irq_pend[2:0]};

    // exc_valid > interrupt > mret_valid; losers are dropped this cycle
    assign w_take_exc  = w_idle & exc_valid;
    assign w_take_irq  = w_idle & ~exc_valid & w_irq_take;
    assign w_take_mret = w_idle & ~exc_valid & ~w_irq_take & mret_valid;
    assign w_take_trap = w_take_exc | w_take_irq;

    assign w_trap_epc   = exc_valid ? exc_pc : irq_pc;
    assign w_trap_cause = exc_valid ? {{(XLEN-5){1'b0}}, exc_cause}
                                    : {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
    assign w_trap_tval  = exc_valid ? exc_tval : '0;

    always_comb begin
        w_trap_mstatus        = r_mstatus;
        w_trap_mstatus[7]     = r_mstatus[3];
        w_trap_mstatus[3]     = 1'b0;
        w_trap_mstatus[12:11] = 2'b11;
    end

    always_comb begin
        w_mret_mstatus        = mstatus_q;
        w_mret_mstatus[3]     = mstatus_q[7];
        w_mret_mstatus[7]     = 1'b1;
        w_mret_mstatus[12:11] = 2'b11;
    end

    assign w_tvec_base   = r_mtvec & ~XLEN'(3);
    assign w_vectored    = (TVEC_VECTORED_EN != 0) && (r_mtvec[1:0] == 2'b01) &&
                           r_cause[XLEN-1];
    assign w_trap_target = w_vectored
                         ? w_tvec_base + ({{(XLEN-5){1'b0}}, r_cause[4:0]} << 2)
                         : w_tvec_base;

    // Outputs are registered, so each state's write is prepared on the edge entering it
    always_comb begin
        w_state_d    = r_state;
        w_we_d       = 1'b0;
        w_waddr_d    = r_csr_waddr;
        w_wdata_d    = r_csr_wdata;
        w_redir_d    = 1'b0;
        w_redir_pc_d = r_redir_pc;
        unique case (r_state)
            StIdle: begin
                if (w_take_trap) begin
                    w_state_d = StWMepc;
                    w_we_d    = 1'b1;
                    w_waddr_d = ADDR_MEPC;
                    w_wdata_d = w_trap_epc;
                end else if (w_take_mret) begin
                    w_state_d = StMMstat;
                    w_we_d    = 1'b1;
                    w_waddr_d = ADDR_MSTATUS;
                    w_wdata_d = w_mret_mstatus;
                end
            end
            StWMepc: begin
                w_state_d = StWMcause;
                w_we_d    = 1'b1;
                w_waddr_d = ADDR_MCAUSE;
                w_wdata_d = r_cause;
            end
            StWMcause: begin
                w_state_d = StWMtval;
                w_we_d    = 1'b1;
                w_waddr_d = ADDR_MTVAL;
                w_wdata_d = r_tval;
            end
            StWMtval: begin
                w_state_d = StWMstat;
                w_we_d    = 1'b1;
                w_waddr_d = ADDR_MSTATUS;
                w_wdata_d = w_trap_mstatus;
            end
            StWMstat: begin
                w_state_d    = StRedir;
                w_redir_d    = 1'b1;
                w_redir_pc_d = w_trap_target;
            end
            StMMstat: begin
                w_state_d    = StRedir;
                w_redir_d    = 1'b1;
                w_redir_pc_d = r_epc & ~XLEN'(1);
            end
            StRedir: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_epc       <= '0;
            r_cause     <= '0;
            r_tval      <= '0;
            r_mstatus   <= '0;
            r_mtvec     <= '0;
            r_csr_we    <= 1'b0;
            r_csr_waddr <= '0;
            r_csr_wdata <= '0;
            r_redir     <= 1'b0;
            r_redir_pc  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_csr_we    <= w_we_d;
            r_csr_waddr <= w_waddr_d;
            r_csr_wdata <= w_wdata_d;
            r_redir     <= w_redir_d;
            r_redir_pc  <= w_redir_pc_d;
            if (w_take_trap) begin
                r_epc     <= w_trap_epc;
                r_cause   <= w_trap_cause;
                r_tval    <= w_trap_tval;
                r_mstatus <= mstatus_q;
                r_mtvec   <= mtvec_q;
            end else if (w_take_mret) begin
                r_epc     <= mepc_q;
                r_mstatus <= mstatus_q;
            end
        end
    end

    assign exc_ready      = w_idle;
    assign csr_busy       = ~w_idle;
    assign csr_we         = r_csr_we;
    assign csr_waddr      = r_csr_waddr;
    assign csr_wdata      = r_csr_wdata;
    assign redirect_valid = r_redir;
    assign redirect_pc    = r_redir_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl
//   Directed bench for csr_trap_ctrl. Stimulus pushes the hand-computed
//   write/redirect events (with their expected cycle) into a queue; a
//   negedge monitor pops and compares every output event the DUT presents.

module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic        exc_ready;
    logic [4:0]  exc_cause;
    logic [31:0] exc_pc;
    logic [31:0] exc_tval;
    logic        mret_valid;
    logic        irq_ok;
    logic [31:0] irq_pc;
    logic [31:0] mstatus_q;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_trap_ctrl #(
        .XLEN            (32),
        .TVEC_VECTORED_EN(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exc_valid     (exc_valid),
        .exc_ready     (exc_ready),
        .exc_cause     (exc_cause),
        .exc_pc        (exc_pc),
        .exc_tval      (exc_tval),
        .mret_valid    (mret_valid),
        .irq_ok        (irq_ok),
        .irq_pc        (irq_pc),
        .mstatus_q     (mstatus_q),
        .mie_q         (mie_q),
        .mip_q         (mip_q),
        .mtvec_q       (mtvec_q),
        .mepc_q        (mepc_q),
        .csr_we        (csr_we),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .csr_busy      (csr_busy),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit          is_redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          at;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every write strobe or redirect must match the next expected event
    always @(negedge clk) begin : monitor
        ev_t e;
        bit  ok;
        if (csr_we === 1'b1 || redirect_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: we=%0b addr=0x%0h data=0x%0h redir=%0b pc=0x%0h, nothing expected (cycle %0d)",
                         csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, cyc);
            end else begin
                e  = exp_q.pop_front();
                ok = (redirect_valid === e.is_redir) && (csr_we === !e.is_redir) &&
                     (cyc == e.at) &&
                     (e.is_redir ? (redirect_pc === e.data)
                                 : (csr_waddr === e.addr && csr_wdata === e.data));
                if (!ok) begin
                    n_err++;
                    $display("FAIL event: got we=%0b addr=0x%0h data=0x%0h redir=%0b pc=0x%0h at cycle %0d; expected redir=%0b addr=0x%0h data=0x%0h at cycle %0d",
                             csr_we, csr_waddr, csr_wdata, redirect_valid, redirect_pc, cyc,
                             e.is_redir, e.addr, e.data, e.at);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input int at, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.is_redir = 1'b0;
        e.addr     = a;
        e.data     = d;
        e.at       = at;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input int at, input logic [31:0] pc);
        ev_t e;
        e.is_redir = 1'b1;
        e.addr     = 12'h000;
        e.data     = pc;
        e.at       = at;
        exp_q.push_back(e);
    endtask

    task automatic push_trap(input int n, input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] mst,
                             input logic [31:0] tgt);
        push_w(n + 1, 12'h341, epc);
        push_w(n + 2, 12'h342, cause);
        push_w(n + 3, 12'h343, tval);
        push_w(n + 4, 12'h300, mst);
        push_r(n + 5, tgt);
    endtask

    // Bounded wait for all expected events and a return to idle
    task automatic wait_done(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || exc_ready !== 1'b1) && k < 30) begin
            tick();
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, {31'b0, exc_ready}, 32'd1);
        repeat (2) tick();
    endtask

    task automatic clear_inputs();
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        irq_ok     = 1'b0;
        mie_q      = '0;
        mip_q      = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst        = 1'b1;
        exc_cause  = '0;
        exc_pc     = '0;
        exc_tval   = '0;
        irq_pc     = '0;
        mstatus_q  = '0;
        mtvec_q    = '0;
        mepc_q     = '0;
        clear_inputs();
        repeat (3) tick();

        check("rst_csr_we", {31'b0, csr_we}, 32'd0);
        check("rst_csr_waddr", {20'b0, csr_waddr}, 32'd0);
        check("rst_csr_wdata", csr_wdata, 32'd0);
        check("rst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_csr_busy", {31'b0, csr_busy}, 32'd0);
        check("rst_exc_ready", {31'b0, exc_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Plain exception, direct mtvec
        mtvec_q   = 32'h800;
        mstatus_q = 32'h8;
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc    = 32'h100;
        exc_tval  = 32'hDEAD;
        n = cyc;
        check("exc_ready_accept", {31'b0, exc_ready}, 32'd1);
        push_trap(n, 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h800);
        tick();
        clear_inputs();
        wait_done("exc");

        // Vectored MTI
        mtvec_q   = 32'h801;
        mstatus_q = 32'h8;
        mie_q     = 32'h80;
        mip_q     = 32'h80;
        irq_ok    = 1'b1;
        irq_pc    = 32'h200;
        n = cyc;
        push_trap(n, 32'h200, 32'h80000007, 32'h0, 32'h1880, 32'h81C);
        tick();
        clear_inputs();
        wait_done("mti");

        // Exception beats pending MEI and MRET in the same cycle
        mtvec_q    = 32'h801;
        mstatus_q  = 32'h8;
        mie_q      = 32'h800;
        mip_q      = 32'h800;
        irq_ok     = 1'b1;
        irq_pc     = 32'h600;
        mret_valid = 1'b1;
        mepc_q     = 32'h700;
        exc_valid  = 1'b1;
        exc_cause  = 5'd1;
        exc_pc     = 32'h500;
        exc_tval   = 32'h44;
        n = cyc;
        push_trap(n, 32'h500, 32'h1, 32'h44, 32'h1880, 32'h800);
        tick();
        clear_inputs();
        wait_done("prio");

        // MEI and MTI pending together: MEI wins, vectored by 11
        mtvec_q   = 32'h801;
        mstatus_q = 32'h88;
        mie_q     = 32'h880;
        mip_q     = 32'h880;
        irq_ok    = 1'b1;
        irq_pc    = 32'h240;
        n = cyc;
        push_trap(n, 32'h240, 32'h8000000B, 32'h0, 32'h1880, 32'h82C);
        tick();
        clear_inputs();
        wait_done("mei_mti");

        // Interrupt masked by mstatus.MIE=0
        mstatus_q = 32'h0;
        mie_q     = 32'h80;
        mip_q     = 32'h80;
        irq_ok    = 1'b1;
        tick();
        check("masked_irq_busy", {31'b0, csr_busy}, 32'd0);
        check("masked_irq_ready", {31'b0, exc_ready}, 32'd1);
        clear_inputs();
        repeat (3) tick();

        // MRET; later mepc/mstatus changes must not leak in
        mstatus_q  = 32'h1880;
        mepc_q     = 32'h403;
        mret_valid = 1'b1;
        n = cyc;
        check("mret_ready_accept", {31'b0, exc_ready}, 32'd1);
        push_w(n + 1, 12'h300, 32'h1888);
        push_r(n + 2, 32'h402);
        tick();
        clear_inputs();
        mepc_q    = 32'hFFF;
        mstatus_q = 32'h0;
        check("mret_ready_n1", {31'b0, exc_ready}, 32'd0);
        tick();
        check("mret_ready_n2", {31'b0, exc_ready}, 32'd0);
        tick();
        check("mret_ready_n3", {31'b0, exc_ready}, 32'd1);
        wait_done("mret");

        // Reset while in W_MTVAL, then a full new sequence
        mtvec_q   = 32'h800;
        mstatus_q = 32'h8;
        exc_valid = 1'b1;
        exc_cause = 5'd4;
        exc_pc    = 32'h110;
        exc_tval  = 32'h55;
        n = cyc;
        push_w(n + 1, 12'h341, 32'h110);
        push_w(n + 2, 12'h342, 32'h4);
        push_w(n + 3, 12'h343, 32'h55);
        tick();
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_csr_we", {31'b0, csr_we}, 32'd0);
        check("midrst_redirect_valid", {31'b0, redirect_valid}, 32'd0);
        check("midrst_exc_ready", {31'b0, exc_ready}, 32'd1);
        check("midrst_csr_busy", {31'b0, csr_busy}, 32'd0);
        rst       = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 5'd6;
        exc_pc    = 32'h120;
        exc_tval  = 32'h66;
        n = cyc;
        push_trap(n, 32'h120, 32'h6, 32'h66, 32'h1880, 32'h800);
        tick();
        clear_inputs();
        wait_done("post_rst");

        // exc_valid held through the sequence; inputs change while busy
        mtvec_q   = 32'h800;
        mstatus_q = 32'h8;
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc    = 32'h100;
        exc_tval  = 32'hDEAD;
        n = cyc;
        push_trap(n, 32'h100, 32'h2, 32'hDEAD, 32'h1880, 32'h800);
        tick();
        exc_cause = 5'd5;
        exc_pc    = 32'h300;
        exc_tval  = 32'h1234;
        mtvec_q   = 32'h901;
        mstatus_q = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("busy_ready_n%0d", k), {31'b0, exc_ready}, 32'd0);
            check($sformatf("busy_busy_n%0d", k), {31'b0, csr_busy}, 32'd1);
            tick();
        end
        check("busy_ready_n6", {31'b0, exc_ready}, 32'd1);
        push_trap(n + 6, 32'h300, 32'h5, 32'h1234, 32'h1800, 32'h900);
        tick();
        clear_inputs();
        wait_done("busy");

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
